fetch_controller: RTL and testbench

// - Sequences the synchronous instruction memory (32-bit address A, 32-bit word RD, 1-cycle read

---
 rtl/fetch_controller.sv | 158 +++++++++++++++
 tb/tb_fetch_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues one instruction-memory read per cycle,
// and buffers returned words in a 2-entry FIFO toward decode. Handles branch
// redirects and halts permanently (until reset) on a misaligned or out-of-range PC.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] A,
    input  logic [31:0] RD,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] issue_pc_q, issue_pc_d;
    logic        inflight_q, inflight_d;
    logic        fault_q, fault_d;
    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic        redirect;
    logic        pc_bad;
    logic [2:0]  credit;
    logic [1:0]  count_after_pop;

    // Next-state logic: FSM, issue/credit decision, redirect and FIFO update.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        issue_pc_d      = issue_pc_q;
        inflight_d      = 1'b0;
        fault_d         = fault_q;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        issue           = 1'b0;

        pop             = (count_q != 2'd0) && instr_ready;
        redirect        = (state_q == FETCH) && branch_valid;
        push            = inflight_q && !redirect;
        pc_bad          = (pc_q > LAST_PC) || (pc_q[1:0] != 2'b00);
        credit          = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        count_after_pop = count_q - {1'b0, pop};

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (branch_target[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (credit < 3'd2) begin
                    if (pc_bad) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            inflight_d = 1'b1;
            issue_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
        end

        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                head_d = '{word: RD, pc: issue_pc_q};
            end else begin
                tail_d = '{word: RD, pc: issue_pc_q};
            end
        end
        count_d = count_after_pop + {1'b0, push};

        if (redirect) begin
            count_d = 2'd0;
        end
    end

    // State registers; asynchronous reset discards all buffered and in-flight words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            issue_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // The credit rule must never allow a push into a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (!rst)
                     !(push && !pop && (count_q == 2'd2)));

    assign A           = pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = head_q.word;
    assign instr_pc    = head_q.pc;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch_controller with a 1-cycle
// synchronous instruction memory preloaded with word[i] = i.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] A;
    logic [31:0] RD;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fault;

    logic [31:0] imem [256];
    int          checks = 0;
    int          errors = 0;

    fetch_controller #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .A             (A),
        .RD            (RD),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .fault         (fault)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        RD <= imem[A[9:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then settle past it.
    task automatic applyStimulus(input logic e, input logic rdy,
                                 input logic bv, input logic [31:0] bt);
        en            = e;
        instr_ready   = rdy;
        branch_valid  = bv;
        branch_target = bt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'(i);
        rst           = 1'b0;
        en            = 1'b0;
        instr_ready   = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_pc", instr_pc, 32'd0);
        checkOutput("reset_fault", {31'b0, fault}, 32'd0);
        checkOutput("reset_A", A, 32'd0);
        rst = 1'b1;

        // Start: en sampled, first issue next cycle, valid two edges after en.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("start_valid_e0", {31'b0, instr_valid}, 32'd0);
        checkOutput("start_A_e0", A, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("start_valid_e1", {31'b0, instr_valid}, 32'd0);
        checkOutput("start_A_e1", A, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("start_valid_e2", {31'b0, instr_valid}, 32'd1);
        checkOutput("start_instr_e2", instr, 32'h0);
        checkOutput("start_pc_e2", instr_pc, 32'h0);
        checkOutput("start_A_e2", A, 32'h8);

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("stream_instr", instr, 32'(k));
            checkOutput("stream_pc", instr_pc, 32'(4 * k));
            checkOutput("stream_A", A, 32'(4 * (k + 2)));
        end

        // Backpressure: two words buffered, address frozen.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_A", A, 32'd20);
        end
        checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("stall_instr", instr, 32'd3);
        checkOutput("stall_pc", instr_pc, 32'd12);

        for (int k = 4; k <= 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("resume_instr", instr, 32'(k));
            checkOutput("resume_pc", instr_pc, 32'(4 * k));
            checkOutput("resume_A", A, 32'(4 * (k + 2)));
        end

        // Redirect to 0x40 with one word buffered and one in flight.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("redir_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("redir_A", A, 32'h40);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_valid_1", {31'b0, instr_valid}, 32'd0);
        checkOutput("redir_A_1", A, 32'h44);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_valid_2", {31'b0, instr_valid}, 32'd1);
        checkOutput("redir_instr", instr, 32'd16);
        checkOutput("redir_pc", instr_pc, 32'h40);
        checkOutput("redir_A_2", A, 32'h48);

        // Misaligned target faults and freezes the PC; later branches are ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h42);
        checkOutput("misalign_fault", {31'b0, fault}, 32'd1);
        checkOutput("misalign_A", A, 32'h48);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
        checkOutput("halt_branch_A", A, 32'h48);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("halt_fault", {31'b0, fault}, 32'd1);
            checkOutput("halt_A", A, 32'h48);
        end

        // Asynchronous reset clears the sticky fault without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset_halt_fault", {31'b0, fault}, 32'd0);
        checkOutput("areset_halt_A", A, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Run to the top of memory: last word 0x3FC delivered, then fault.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3F0);
        checkOutput("top_redir_A", A, 32'h3F0);
        checkOutput("top_redir_valid", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("top_A_1", A, 32'h3F4);
        for (int k = 252; k <= 254; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("top_instr", instr, 32'(k));
            checkOutput("top_pc", instr_pc, 32'(4 * k));
            checkOutput("top_A", A, 32'(4 * (k + 2)));
            checkOutput("top_fault_low", {31'b0, fault}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("top_fault", {31'b0, fault}, 32'd1);
        checkOutput("top_last_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("top_last_instr", instr, 32'd255);
        checkOutput("top_last_pc", instr_pc, 32'h3FC);
        checkOutput("top_last_A", A, 32'h400);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("top_drained_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("top_drained_fault", {31'b0, fault}, 32'd1);
        checkOutput("top_drained_A", A, 32'h400);

        // Asynchronous reset mid-stream, between clock edges.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("mid_instr", instr, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("areset_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("areset_fault", {31'b0, fault}, 32'd0);
        checkOutput("areset_A", A, 32'h0);
        checkOutput("areset_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("idle_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("idle_A", A, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
